// File: rtl/i2c_mem_cmd_sched.sv
// i2c_mem_cmd_sched: queues read/write commands for the I2C memory engine, holds mem_* for a whole slot,
// fills idle slots with dummy reads of address 0 and returns completions in order.
// Ports: cmd_* valid/ready command input; rsp_* valid/ready response output (rdata 0 on writes/errors,
// err on timeout); mem_* drive the engine, mem_datard_i/mem_done_i are its result and completion pulse;
// busy_o = work queued or a real command in flight; stall_o = sticky dummy/sync-slot timeout flag.
module i2c_mem_cmd_sched #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic       cmd_wr_i,
   input  logic [6:0] cmd_addr_i,
   input  logic [7:0] cmd_wdata_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic       rsp_wr_o,
   output logic [6:0] rsp_addr_o,
   output logic [7:0] rsp_rdata_o,
   output logic       rsp_err_o,
   output logic       mem_wr_o,
   output logic [6:0] mem_addr_o,
   output logic [7:0] mem_din_o,
   input  logic [7:0] mem_datard_i,
   input  logic       mem_done_i,
   output logic       busy_o,
   output logic       stall_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {SYNC, DUMMY, REAL} state_t;
   state_t          state_q, state_d;
   logic [15:0]     fifo_q [DEPTH];
   logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [16:0]     rq_q [2];
   logic            rhead_q, rhead_d;
   logic [1:0]      rcnt_q, rcnt_d, rocc;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            mwr_q, mwr_d, stall_q, stall_d;
   logic [6:0]      maddr_q, maddr_d;
   logic [7:0]      mdin_q, mdin_d;
   logic            push, pop, tmo, rsp_we, rsp_pop, widx;
   logic [16:0]     rsp_ent;
   assign cmd_ready_o = cnt_q != CW'(DEPTH);
   assign rsp_valid_o = rcnt_q != 2'd0;
   assign {rsp_wr_o, rsp_addr_o, rsp_rdata_o, rsp_err_o} = rq_q[rhead_q];
   assign mem_wr_o    = mwr_q;
   assign mem_addr_o  = maddr_q;
   assign mem_din_o   = mdin_q;
   assign busy_o      = cnt_q != '0 || state_q == REAL;
   assign stall_o     = stall_q;
   always_comb begin
      push    = cmd_valid_i && cmd_ready_o;
      rsp_pop = rsp_valid_o && rsp_ready_i;
      // mem_done wins over a timeout landing on the same edge
      tmo     = !mem_done_i && tcnt_q == TW'(TIMEOUT - 1);
      rsp_we  = state_q == REAL && (mem_done_i || tmo);
      // a REAL slot always finds a free response entry since dispatch leaves at most one occupied
      widx    = rhead_q ^ rcnt_q[0];
      rsp_ent = {mwr_q, maddr_q, (mwr_q || tmo) ? 8'h00 : mem_datard_i, tmo};
      rocc    = rcnt_q + {1'b0, rsp_we} - {1'b0, rsp_pop};
      pop     = mem_done_i && cnt_q != '0 && rocc <= 2'd1;
      rcnt_d  = rocc;
      rhead_d = rhead_q ^ rsp_pop;
      wp_d    = push ? wp_q + AW'(1) : wp_q;
      rp_d    = pop ? rp_q + AW'(1) : rp_q;
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      state_d = state_q;
      mwr_d   = mwr_q;
      maddr_d = maddr_q;
      mdin_d  = mdin_q;
      if (mem_done_i) begin
         state_d = pop ? REAL : DUMMY;
         {mwr_d, maddr_d, mdin_d} = pop ? fifo_q[rp_q] : 16'h0;
      end else if (tmo && state_q == REAL) begin
         state_d = SYNC;
         {mwr_d, maddr_d, mdin_d} = 16'h0;
      end
      stall_d = mem_done_i ? 1'b0 : (tmo && state_q != REAL) ? 1'b1 : stall_q;
      // a REAL timeout also restarts the count so a hung SYNC slot is flagged a full TIMEOUT later
      tcnt_d  = (mem_done_i || (tmo && state_q == REAL)) ? '0 :
                (tcnt_q == TW'(TIMEOUT)) ? tcnt_q : tcnt_q + TW'(1);
   end
   always_ff @(posedge clk) begin
      if (push) fifo_q[wp_q] <= {cmd_wr_i, cmd_addr_i, cmd_wdata_i};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SYNC;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         rq_q[0] <= '0;
         rq_q[1] <= '0;
         rhead_q <= 1'b0;
         rcnt_q  <= 2'd0;
         tcnt_q  <= '0;
         mwr_q   <= 1'b0;
         maddr_q <= 7'h0;
         mdin_q  <= 8'h0;
         stall_q <= 1'b0;
      end else begin
         if (rsp_we) rq_q[widx] <= rsp_ent;
         state_q <= state_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         rhead_q <= rhead_d;
         rcnt_q  <= rcnt_d;
         tcnt_q  <= tcnt_d;
         mwr_q   <= mwr_d;
         maddr_q <= maddr_d;
         mdin_q  <= mdin_d;
         stall_q <= stall_d;
      end
   end
endmodule

// File: tb/tb_i2c_mem_cmd_sched.sv
// tb_i2c_mem_cmd_sched: directed bench for i2c_mem_cmd_sched with a small engine model (8-cycle slots)
module tb_i2c_mem_cmd_sched;
   logic       clk = 0, rst = 1;
   logic       cmd_valid = 0, cmd_ready, cmd_wr = 0;
   logic [6:0] cmd_addr = 0;
   logic [7:0] cmd_wdata = 0;
   logic       rsp_valid, rsp_ready = 1, rsp_wr, rsp_err;
   logic [6:0] rsp_addr;
   logic [7:0] rsp_rdata;
   logic       mem_wr, mem_done = 0, busy, stall;
   logic [6:0] mem_addr;
   logic [7:0] mem_din, mem_datard = 0;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   i2c_mem_cmd_sched #(.DEPTH(4), .TIMEOUT(1023)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_wr_o(rsp_wr),
      .rsp_addr_o(rsp_addr), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
      .mem_datard_i(mem_datard), .mem_done_i(mem_done),
      .busy_o(busy), .stall_o(stall)
   );
   // engine model: done raised at ph 7->0, addr/wr/din sampled two edges later, op performed at slot end
   logic [7:0] emem [128];
   logic       eng_en = 1, lwr = 0;
   logic [6:0] laddr = 0;
   logic [7:0] ldin = 0;
   int         ph = 0, n_engwr = 0;
   initial for (int i = 0; i < 128; i++) emem[i] = 8'h00;
   always @(posedge clk) begin
      mem_done <= 1'b0;
      if (eng_en) begin
         ph <= (ph == 7) ? 0 : ph + 1;
         if (ph == 1) begin
            lwr   <= mem_wr;
            laddr <= mem_addr;
            ldin  <= mem_din;
         end
         if (ph == 7) begin
            if (lwr) begin
               emem[laddr] <= ldin;
               n_engwr     <= n_engwr + 1;
            end
            mem_datard <= emem[laddr];
            mem_done   <= 1'b1;
         end
      end
   end
   logic [16:0] rq [$];
   int n_memwr = 0, n_addrnz = 0, n_full = 0;
   always @(posedge clk) begin
      if (!rst && rsp_valid && rsp_ready) rq.push_back({rsp_wr, rsp_addr, rsp_rdata, rsp_err});
      if (!rst && mem_wr) n_memwr <= n_memwr + 1;
      if (!rst && mem_addr != 0) n_addrnz <= n_addrnz + 1;
      if (!rst && !cmd_ready) n_full <= n_full + 1;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1; cmd_wr = w; cmd_addr = a; cmd_wdata = d;
      while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
      chk("send_ready", {31'b0, cmd_ready}, 1);
      @(posedge clk);
      #1 cmd_valid = 0;
   endtask
   task automatic wait_rsp(input int n, input string tag);
      int k = 0;
      while (rq.size() < n && k < 2000) begin @(negedge clk); k++; end
      chk(tag, {31'b0, rq.size() >= n}, 1);
   endtask
   task automatic chk_rsp(input int idx, input logic [16:0] exp, input string tag);
      chk(tag, (idx < rq.size()) ? {15'b0, rq[idx]} : 32'hFFFF_FFFF, {15'b0, exp});
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_outs"}, {cmd_ready, rsp_valid, rsp_wr, rsp_addr, rsp_rdata, rsp_err},
          {1'b1, 1'b0, 1'b0, 7'h0, 8'h0, 1'b0});
      chk({tag, "_mem"}, {mem_wr, mem_addr, mem_din, busy, stall}, {1'b0, 7'h0, 8'h0, 1'b0, 1'b0});
   endtask
   initial begin
      int a0, b0, c0, f0, cnt, sz0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 0;
      // idle: only dummy reads of address 0
      a0 = n_memwr; b0 = n_addrnz; c0 = n_engwr;
      repeat (5000) @(negedge clk);
      chk("idle_memwr", n_memwr - a0, 0);
      chk("idle_addr", n_addrnz - b0, 0);
      chk("idle_engwr", n_engwr - c0, 0);
      chk("idle_rsp", rq.size(), 0);
      chk("idle_stall", {31'b0, stall}, 0);
      // write then read back
      send(1, 7'h12, 8'h5A);
      send(0, 7'h12, 8'h00);
      wait_rsp(2, "wr_rd_arrive");
      chk_rsp(0, {1'b1, 7'h12, 8'h00, 1'b0}, "wr_rsp");
      chk_rsp(1, {1'b0, 7'h12, 8'h5A, 1'b0}, "rd_rsp");
      // six back-to-back writes fill the FIFO
      f0 = n_full;
      for (int i = 0; i < 6; i++) send(1, 7'h20 + 7'(i), 8'h30 + 8'(i));
      chk("full_seen", {31'b0, n_full > f0}, 1);
      wait_rsp(8, "six_arrive");
      for (int i = 0; i < 6; i++) chk_rsp(2 + i, {1'b1, 7'h20 + 7'(i), 8'h00, 1'b0}, "six_rsp");
      // response backpressure: two complete, the rest wait, engine sees dummies
      @(negedge clk); rsp_ready = 0;
      for (int i = 0; i < 4; i++) send(0, 7'h20 + 7'(i), 8'h00);
      repeat (100) @(negedge clk);
      chk("bp_head", {rsp_valid, rsp_wr, rsp_addr, rsp_rdata, rsp_err}, {1'b1, 1'b0, 7'h20, 8'h30, 1'b0});
      chk("bp_dummy", {mem_wr, mem_addr}, 0);
      chk("bp_state", {cmd_ready, busy}, 2'b11);
      chk("bp_none_popped", rq.size(), 8);
      repeat (50) @(negedge clk);
      chk("bp_stable", {rsp_valid, rsp_wr, rsp_addr, rsp_rdata, rsp_err}, {1'b1, 1'b0, 7'h20, 8'h30, 1'b0});
      rsp_ready = 1;
      wait_rsp(12, "bp_arrive");
      for (int i = 0; i < 4; i++) chk_rsp(8 + i, {1'b0, 7'h20 + 7'(i), 8'h30 + 8'(i), 1'b0}, "bp_rsp");
      // timeout on a hung REAL write
      @(negedge clk); rsp_ready = 0;
      send(1, 7'h33, 8'h77);
      cnt = 0;
      while (!(mem_wr && mem_addr == 7'h33) && cnt < 100) begin @(negedge clk); cnt++; end
      chk("tmo_dispatch", {mem_wr, mem_addr}, {1'b1, 7'h33});
      eng_en = 0;
      cnt = 0;
      while (!rsp_valid && cnt < 1200) begin @(negedge clk); cnt++; end
      chk("tmo_latency", cnt, 1023);
      chk("tmo_rsp", {rsp_wr, rsp_addr, rsp_rdata, rsp_err}, {1'b1, 7'h33, 8'h00, 1'b1});
      chk("tmo_sync", {mem_wr, mem_addr, mem_din, busy, stall}, 0);
      rsp_ready = 1;
      while (cnt < 2045) begin @(negedge clk); cnt++; end
      chk("stall_early", {31'b0, stall}, 0);
      @(negedge clk);
      chk("stall_set", {31'b0, stall}, 1);
      chk_rsp(12, {1'b1, 7'h33, 8'h00, 1'b1}, "tmo_queue");
      eng_en = 1;
      cnt = 0;
      while (!mem_done && cnt < 50) begin @(negedge clk); cnt++; end
      @(negedge clk);
      chk("stall_clear", {31'b0, stall}, 0);
      // reset with a REAL read in flight and two queued
      for (int i = 0; i < 3; i++) send(0, 7'h20 + 7'(i), 8'h00);
      cnt = 0;
      while (!(mem_addr == 7'h20) && cnt < 100) begin @(negedge clk); cnt++; end
      chk("rst_inflight", {mem_wr, mem_addr}, {1'b0, 7'h20});
      sz0 = rq.size();
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk_reset("midrst");
      repeat (40) @(negedge clk);
      chk("midrst_no_stale", rq.size(), sz0);
      send(0, 7'h21, 8'h00);
      wait_rsp(sz0 + 1, "midrst_arrive");
      chk_rsp(sz0, {1'b0, 7'h21, 8'h31, 1'b0}, "midrst_rsp");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
